// File: rtl/fetch_decode_queue.sv
// ---------------------------------------------------------------------------
// fetch_decode_queue
//
// Purpose:
//   Decoupling instruction queue between fetch and decode. Fetch pushes up to
//   SUPER_SCALAR_WIDTH aligned instructions per cycle, each tagged with its
//   PC, into a circular buffer. Decode sees the oldest SUPER_SCALAR_WIDTH
//   entries combinationally and reports how many it consumed. A misprediction
//   flush empties the queue.
//
// Optional feature:
//   FDQ_NOP_FILTER_EN - when defined, NOP slots (32'hD503201F) are dropped at
//   enqueue and the surviving slots are compacted in order, each keeping its
//   own PC. When undefined, NOPs are queued like any other instruction.
//
// Ports:
//   clk_in              clock
//   rst_in              synchronous active-high reset
//   flush_in            misprediction flush, empties the queue
//   enq_valid_in        fetch bundle valid
//   enq_count_in        number of valid bundle slots (slots 0..count-1)
//   enq_instrs_in       bundle instructions, slot i at [i*IW +: IW], slot 0 oldest
//   enq_pc_in           PC of slot 0; slot i sits at enq_pc_in + 4*i
//   enq_ready_out       queue can accept a full bundle this cycle
//   deq_instrs_out      oldest instructions, slot 0 oldest, invalid slots 0
//   deq_pcs_out         PCs matching deq_instrs_out, slot i at [i*64 +: 64]
//   deq_valid_count_out min(occupancy, SUPER_SCALAR_WIDTH)
//   deq_take_in         instructions consumed by decode this cycle
//   occupancy_out       current entry count
// ---------------------------------------------------------------------------
module fetch_decode_queue #(
  parameter int INSTRUCTION_WIDTH  = 32,
  parameter int SUPER_SCALAR_WIDTH = 4,
  parameter int DEPTH              = 16,
  parameter int CW                 = $clog2(SUPER_SCALAR_WIDTH + 1)
) (
  input  logic                                            clk_in,
  input  logic                                            rst_in,
  input  logic                                            flush_in,
  input  logic                                            enq_valid_in,
  input  logic [CW-1:0]                                   enq_count_in,
  input  logic [SUPER_SCALAR_WIDTH*INSTRUCTION_WIDTH-1:0] enq_instrs_in,
  input  logic [63:0]                                     enq_pc_in,
  output logic                                            enq_ready_out,
  output logic [SUPER_SCALAR_WIDTH*INSTRUCTION_WIDTH-1:0] deq_instrs_out,
  output logic [SUPER_SCALAR_WIDTH*64-1:0]                deq_pcs_out,
  output logic [CW-1:0]                                   deq_valid_count_out,
  input  logic [CW-1:0]                                   deq_take_in,
  output logic [$clog2(DEPTH+1)-1:0]                      occupancy_out
);

  localparam int IW  = INSTRUCTION_WIDTH;
  localparam int SSW = SUPER_SCALAR_WIDTH;
  localparam int AW  = $clog2(DEPTH);
  localparam int OW  = $clog2(DEPTH + 1);

`ifdef FDQ_NOP_FILTER_EN
  localparam logic [IW-1:0] NOP_ENCODING = IW'(32'hD503201F);
`endif

  // Entry storage; deliberately not reset, the valid count gates the outputs
  logic [IW-1:0] r_instrMem [DEPTH];
  logic [63:0]   r_pcMem    [DEPTH];

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [OW-1:0] r_count;

  logic          w_enqFire;
  logic [SSW-1:0] w_keep;
  logic [CW-1:0] w_pos [SSW];
  logic [CW-1:0] w_keptCount;
  logic [CW-1:0] w_enqN;
  logic [CW-1:0] w_validCount;
  logic [CW-1:0] w_take;

  // Ready depends only on the registered count, so a dequeue in the same
  // cycle never frees space early.
  assign enq_ready_out = (r_count <= OW'(DEPTH - SSW));
  assign w_enqFire     = enq_valid_in & enq_ready_out & ~flush_in;
  assign occupancy_out = r_count;

  // Slot selection and compaction: each kept slot lands at tail plus the
  // number of kept slots before it, so dropped NOPs leave no holes.
  always_comb begin
    w_keep      = '0;
    w_pos       = '{default: '0};
    w_keptCount = '0;
    for (int i = 0; i < SSW; i++) begin
      w_pos[i]  = w_keptCount;
      w_keep[i] = (CW'(i) < enq_count_in);
`ifdef FDQ_NOP_FILTER_EN
      if (enq_instrs_in[i*IW +: IW] == NOP_ENCODING) begin
        w_keep[i] = 1'b0;
      end
`endif
      if (w_keep[i]) begin
        w_keptCount = w_keptCount + CW'(1);
      end
    end
  end

  assign w_enqN = w_enqFire ? w_keptCount : '0;

  // Valid slot count, and the take clamped so an empty queue or an
  // over-asking decode can never move head past valid data.
  always_comb begin
    if (r_count >= OW'(SSW)) begin
      w_validCount = CW'(SSW);
    end else begin
      w_validCount = r_count[CW-1:0];
    end
    if (deq_take_in > w_validCount) begin
      w_take = w_validCount;
    end else begin
      w_take = deq_take_in;
    end
  end

  assign deq_valid_count_out = w_validCount;

  // Combinational read of the oldest entries with wrap; slots past the
  // valid count are forced to zero.
  always_comb begin
    deq_instrs_out = '0;
    deq_pcs_out    = '0;
    for (int i = 0; i < SSW; i++) begin
      if (CW'(i) < w_validCount) begin
        deq_instrs_out[i*IW +: IW] = r_instrMem[r_head + AW'(i)];
        deq_pcs_out[i*64 +: 64]    = r_pcMem[r_head + AW'(i)];
      end
    end
  end

  // Entry writes; pointer arithmetic wraps naturally at AW bits.
  always_ff @(posedge clk_in) begin
    if (!rst_in && w_enqFire) begin
      for (int i = 0; i < SSW; i++) begin
        if (w_keep[i]) begin
          r_instrMem[r_tail + AW'(w_pos[i])] <= enq_instrs_in[i*IW +: IW];
          r_pcMem[r_tail + AW'(w_pos[i])]    <= enq_pc_in + 64'(4 * i);
        end
      end
    end
  end

  // Pointer and count update; reset beats flush, flush beats enq/deq.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_take);
      r_tail  <= r_tail + AW'(w_enqN);
      r_count <= r_count + OW'(w_enqN) - OW'(w_take);
    end
  end

  // Decode must never consume more than is presented.
  a_takeLegal : assert property (@(posedge clk_in) disable iff (rst_in || flush_in)
                                 deq_take_in <= deq_valid_count_out);

endmodule

// File: tb/tb_fetch_decode_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode_queue
//
// Self-checking bench for fetch_decode_queue. A queue-based reference model
// tracks the expected contents; directed scenarios and a randomized run
// compare the DUT outputs against it.
// ---------------------------------------------------------------------------
module tb_fetch_decode_queue;

  localparam int IW    = 32;
  localparam int SSW   = 4;
  localparam int DEPTH = 16;
  localparam int CW    = 3;
  localparam int OW    = 5;
  localparam logic [31:0] NOP = 32'hD503201F;

  logic           clk_in = 1'b0;
  logic           rst_in = 1'b1;
  logic           flush_in = 1'b0;
  logic           enq_valid_in = 1'b0;
  logic [CW-1:0]  enq_count_in = '0;
  logic [127:0]   enq_instrs_in = '0;
  logic [63:0]    enq_pc_in = '0;
  logic           enq_ready_out;
  logic [127:0]   deq_instrs_out;
  logic [255:0]   deq_pcs_out;
  logic [CW-1:0]  deq_valid_count_out;
  logic [CW-1:0]  deq_take_in = '0;
  logic [OW-1:0]  occupancy_out;

  int errors = 0;
  int checks = 0;

  // Reference model: in-order contents of the queue
  logic [31:0] mInstr [$];
  logic [63:0] mPc    [$];

  always #5 clk_in = ~clk_in;

  fetch_decode_queue #(
    .INSTRUCTION_WIDTH(IW),
    .SUPER_SCALAR_WIDTH(SSW),
    .DEPTH(DEPTH),
    .CW(CW)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .flush_in(flush_in),
    .enq_valid_in(enq_valid_in),
    .enq_count_in(enq_count_in),
    .enq_instrs_in(enq_instrs_in),
    .enq_pc_in(enq_pc_in),
    .enq_ready_out(enq_ready_out),
    .deq_instrs_out(deq_instrs_out),
    .deq_pcs_out(deq_pcs_out),
    .deq_valid_count_out(deq_valid_count_out),
    .deq_take_in(deq_take_in),
    .occupancy_out(occupancy_out)
  );

  function automatic logic [127:0] expInstrs();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < SSW; i++) if (i < mInstr.size()) r[i*32 +: 32] = mInstr[i];
    return r;
  endfunction

  function automatic logic [255:0] expPcs();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < SSW; i++) if (i < mPc.size()) r[i*64 +: 64] = mPc[i];
    return r;
  endfunction

  function automatic int expValid();
    return (mInstr.size() < SSW) ? mInstr.size() : SSW;
  endfunction

  function automatic logic [127:0] bundle(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  // Drive one cycle, advance the model from the pre-edge state, then return
  // the inputs to idle one time unit after the edge.
  task automatic applyStimulus(input logic rst, input logic flush, input logic valid,
                               input logic [CW-1:0] cnt, input logic [127:0] instrs,
                               input logic [63:0] pc, input logic [CW-1:0] take);
    bit ready;
    logic [31:0] ins;
    rst_in = rst; flush_in = flush; enq_valid_in = valid; enq_count_in = cnt;
    enq_instrs_in = instrs; enq_pc_in = pc; deq_take_in = take;
    ready = (DEPTH - mInstr.size()) >= SSW;
    if (rst || flush) begin
      mInstr.delete();
      mPc.delete();
    end else begin
      for (int k = 0; k < int'(take) && mInstr.size() > 0; k++) begin
        void'(mInstr.pop_front());
        void'(mPc.pop_front());
      end
      if (valid && ready) begin
        for (int i = 0; i < int'(cnt) && i < SSW; i++) begin
          ins = instrs[i*32 +: 32];
`ifdef FDQ_NOP_FILTER_EN
          if (ins == NOP) continue;
`endif
          mInstr.push_back(ins);
          mPc.push_back(pc + 64'(4 * i));
        end
      end
    end
    @(posedge clk_in);
    #1;
    rst_in = 1'b0; flush_in = 1'b0; enq_valid_in = 1'b0; enq_count_in = '0; deq_take_in = '0;
  endtask

  task automatic test_reset();
    applyStimulus(1, 0, 0, 0, '0, '0, 0);
    applyStimulus(1, 0, 0, 0, '0, '0, 0);
    checks++; if (enq_ready_out !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %0b expected 1", enq_ready_out); end
    checks++; if (deq_valid_count_out !== 3'd0) begin errors++; $display("[TB] FAIL reset_valid: got %0d expected 0", deq_valid_count_out); end
    checks++; if (occupancy_out !== 5'd0) begin errors++; $display("[TB] FAIL reset_occ: got %0d expected 0", occupancy_out); end
    checks++; if (deq_instrs_out !== '0) begin errors++; $display("[TB] FAIL reset_instrs: got %h expected 0", deq_instrs_out); end
    checks++; if (deq_pcs_out !== '0) begin errors++; $display("[TB] FAIL reset_pcs: got %h expected 0", deq_pcs_out); end
  endtask

  task automatic test_single_bundle();
    applyStimulus(1, 0, 0, 0, '0, '0, 0);
    applyStimulus(0, 0, 1, 4, {32'hA0000004, 32'hA0000003, 32'hA0000002, 32'hA0000001}, 64'h1000, 0);
    checks++; if (deq_valid_count_out !== 3'd4) begin errors++; $display("[TB] FAIL single_valid: got %0d expected 4", deq_valid_count_out); end
    checks++; if (deq_pcs_out !== {64'h100C, 64'h1008, 64'h1004, 64'h1000}) begin errors++; $display("[TB] FAIL single_pcs: got %h", deq_pcs_out); end
    checks++; if (deq_instrs_out !== {32'hA0000004, 32'hA0000003, 32'hA0000002, 32'hA0000001}) begin errors++; $display("[TB] FAIL single_instrs: got %h", deq_instrs_out); end
    applyStimulus(0, 0, 0, 0, '0, '0, 2);
    checks++; if (occupancy_out !== 5'd2) begin errors++; $display("[TB] FAIL single_take_occ: got %0d expected 2", occupancy_out); end
    checks++; if (deq_instrs_out !== {64'h0, 32'hA0000004, 32'hA0000003}) begin errors++; $display("[TB] FAIL single_take_instrs: got %h", deq_instrs_out); end
    checks++; if (deq_pcs_out !== {128'h0, 64'h100C, 64'h1008}) begin errors++; $display("[TB] FAIL single_take_pcs: got %h", deq_pcs_out); end
  endtask

  task automatic test_fill_full();
    applyStimulus(1, 0, 0, 0, '0, '0, 0);
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 1, 4, bundle(32'h40000000 + 32'(16 * k)), 64'h4000 + 64'(16 * k), 0);
    checks++; if (occupancy_out !== 5'd16) begin errors++; $display("[TB] FAIL full_occ: got %0d expected 16", occupancy_out); end
    checks++; if (enq_ready_out !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %0b expected 0", enq_ready_out); end
    applyStimulus(0, 0, 1, 4, bundle(32'h4F000000), 64'h9000, 0);
    checks++; if (occupancy_out !== 5'd16) begin errors++; $display("[TB] FAIL full_hold_occ: got %0d expected 16", occupancy_out); end
    checks++; if (deq_pcs_out !== expPcs()) begin errors++; $display("[TB] FAIL full_hold_pcs: got %h expected %h", deq_pcs_out, expPcs()); end
    applyStimulus(0, 0, 0, 0, '0, '0, 4);
    checks++; if (enq_ready_out !== 1'b1) begin errors++; $display("[TB] FAIL full_drain_ready: got %0b expected 1", enq_ready_out); end
    checks++; if (occupancy_out !== 5'd12) begin errors++; $display("[TB] FAIL full_drain_occ: got %0d expected 12", occupancy_out); end
    checks++; if (deq_pcs_out[63:0] !== 64'h4010) begin errors++; $display("[TB] FAIL full_drain_head: got %h expected 4010", deq_pcs_out[63:0]); end
  endtask

  task automatic test_wrap_around();
    applyStimulus(1, 0, 0, 0, '0, '0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 1, 4, bundle(32'h30000000 + 32'(4 * k)), 64'h3000 + 64'(16 * k), 0);
    applyStimulus(0, 0, 1, 2, bundle(32'h3000000C), 64'h3030, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, '0, '0, 4);
    applyStimulus(0, 0, 1, 4, bundle(32'h3000000E), 64'h3038, 0);
    checks++; if (occupancy_out !== 5'd6) begin errors++; $display("[TB] FAIL wrap_occ: got %0d expected 6", occupancy_out); end
    checks++; if (deq_pcs_out !== {64'h303C, 64'h3038, 64'h3034, 64'h3030}) begin errors++; $display("[TB] FAIL wrap_pcs: got %h", deq_pcs_out); end
    checks++; if (deq_instrs_out !== {32'h3000000F, 32'h3000000E, 32'h3000000D, 32'h3000000C}) begin errors++; $display("[TB] FAIL wrap_instrs: got %h", deq_instrs_out); end
    applyStimulus(0, 0, 0, 0, '0, '0, 4);
    checks++; if (deq_pcs_out !== {128'h0, 64'h3044, 64'h3040}) begin errors++; $display("[TB] FAIL wrap_tail_pcs: got %h", deq_pcs_out); end
    checks++; if (deq_instrs_out !== {64'h0, 32'h30000011, 32'h30000010}) begin errors++; $display("[TB] FAIL wrap_tail_instrs: got %h", deq_instrs_out); end
  endtask

  task automatic test_flush_simultaneous();
    applyStimulus(1, 0, 0, 0, '0, '0, 0);
    applyStimulus(0, 0, 1, 4, bundle(32'h50000000), 64'h5000, 0);
    applyStimulus(0, 0, 1, 4, bundle(32'h50000004), 64'h5010, 0);
    applyStimulus(0, 1, 1, 4, bundle(32'h50000008), 64'h5020, 3);
    checks++; if (occupancy_out !== 5'd0) begin errors++; $display("[TB] FAIL flush_occ: got %0d expected 0", occupancy_out); end
    checks++; if (deq_valid_count_out !== 3'd0) begin errors++; $display("[TB] FAIL flush_valid: got %0d expected 0", deq_valid_count_out); end
    checks++; if (enq_ready_out !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready: got %0b expected 1", enq_ready_out); end
    applyStimulus(0, 0, 1, 1, bundle(32'h5A000000), 64'h6000, 0);
    checks++; if (deq_pcs_out !== {192'h0, 64'h6000}) begin errors++; $display("[TB] FAIL flush_refill_pcs: got %h", deq_pcs_out); end
  endtask

  task automatic test_nop_filter();
    applyStimulus(1, 0, 0, 0, '0, '0, 0);
    applyStimulus(0, 0, 1, 4, {NOP, 32'hBBBB0002, NOP, 32'hAAAA0001}, 64'h2000, 0);
`ifdef FDQ_NOP_FILTER_EN
    checks++; if (occupancy_out !== 5'd2) begin errors++; $display("[TB] FAIL nop_occ: got %0d expected 2", occupancy_out); end
    checks++; if (deq_instrs_out !== {64'h0, 32'hBBBB0002, 32'hAAAA0001}) begin errors++; $display("[TB] FAIL nop_instrs: got %h", deq_instrs_out); end
    checks++; if (deq_pcs_out !== {128'h0, 64'h2008, 64'h2000}) begin errors++; $display("[TB] FAIL nop_pcs: got %h", deq_pcs_out); end
`else
    checks++; if (occupancy_out !== 5'd4) begin errors++; $display("[TB] FAIL nop_occ: got %0d expected 4", occupancy_out); end
    checks++; if (deq_instrs_out !== {NOP, 32'hBBBB0002, NOP, 32'hAAAA0001}) begin errors++; $display("[TB] FAIL nop_instrs: got %h", deq_instrs_out); end
    checks++; if (deq_pcs_out !== {64'h200C, 64'h2008, 64'h2004, 64'h2000}) begin errors++; $display("[TB] FAIL nop_pcs: got %h", deq_pcs_out); end
`endif
  endtask

  task automatic test_random();
    logic [127:0] ins;
    logic [63:0] pc;
    bit rst, flush, valid;
    int cnt, take;
    applyStimulus(1, 0, 0, 0, '0, '0, 0);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < SSW; i++) ins[i*32 +: 32] = ($urandom_range(0, 4) == 0) ? NOP : $urandom;
      pc    = {$urandom, $urandom & 32'hFFFF_FFFC};
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 29) == 0);
      valid = ($urandom_range(0, 9) < 7);
      cnt   = $urandom_range(0, 4);
      take  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, expValid()) : 0;
      applyStimulus(rst, flush, valid, CW'(cnt), ins, pc, CW'(take));
      checks++; if (occupancy_out !== OW'(mInstr.size())) begin errors++; $display("[TB] FAIL rand_occ c=%0d: got %0d expected %0d", c, occupancy_out, mInstr.size()); end
      checks++; if (enq_ready_out !== ((DEPTH - mInstr.size()) >= SSW)) begin errors++; $display("[TB] FAIL rand_ready c=%0d: got %0b", c, enq_ready_out); end
      checks++; if (deq_valid_count_out !== CW'(expValid())) begin errors++; $display("[TB] FAIL rand_valid c=%0d: got %0d expected %0d", c, deq_valid_count_out, expValid()); end
      checks++; if (deq_instrs_out !== expInstrs()) begin errors++; $display("[TB] FAIL rand_instrs c=%0d: got %h expected %h", c, deq_instrs_out, expInstrs()); end
      checks++; if (deq_pcs_out !== expPcs()) begin errors++; $display("[TB] FAIL rand_pcs c=%0d: got %h expected %h", c, deq_pcs_out, expPcs()); end
    end
  endtask

  initial begin
    test_reset();
    test_single_bundle();
    test_fill_full();
    test_wrap_around();
    test_flush_simultaneous();
    test_nop_filter();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
